// File: rtl/chrono_pkg.sv
// Shared state encodings and default field limits for the stopwatch controller.
package chrono_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_LAP   = 2'b11;

  localparam int unsigned DEF_SEC_MAX = 59;
  localparam int unsigned DEF_MIN_MAX = 59;
  localparam int unsigned DEF_CNT_W   = 6;

endpackage

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) counter with synchronous clear; carry_out flags the wrapping increment.
module mod_counter #(
  parameter int unsigned MAX = 59,
  parameter int unsigned W   = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         carry_out
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  assign carry_out = inc && !clr && (count == MAX_V);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= (count == MAX_V) ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/chrono_ctrl.sv
// Stopwatch run/pause/lap/clear controller with seconds/minutes count.
// Optional lap freeze is compiled in with the LAP_EN macro.
module chrono_ctrl
  import chrono_pkg::*;
#(
  parameter int unsigned SEC_MAX = DEF_SEC_MAX,
  parameter int unsigned MIN_MAX = DEF_MIN_MAX,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_start_stop,
  input  logic             btn_lap,
  input  logic             btn_clear,
  input  logic             tick,
  output logic             start,
  output logic             pause,
  output logic [CNT_W-1:0] sec_out,
  output logic [CNT_W-1:0] min_out,
  output logic             lap_active,
  output logic             overflow
);

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [CNT_W-1:0] sec;
  logic [CNT_W-1:0] min;
  logic             sec_carry;
  logic             min_carry;
  logic             count_en;
  logic             clr;

  // Counting follows the current registered state, even if a button leaves it this cycle.
  assign count_en = tick && ((state == ST_RUN) || (state == ST_LAP));
  assign clr      = btn_clear && ((state == ST_IDLE) || (state == ST_PAUSE));

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (btn_clear)           state_nx = ST_IDLE;
        else if (btn_start_stop) state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (btn_start_stop)      state_nx = ST_PAUSE;
`ifdef LAP_EN
        else if (btn_lap)        state_nx = ST_LAP;
`endif
      end
      ST_PAUSE: begin
        if (btn_clear)           state_nx = ST_IDLE;
        else if (btn_start_stop) state_nx = ST_RUN;
      end
      default: begin
`ifdef LAP_EN
        if (btn_start_stop)      state_nx = ST_PAUSE;
        else if (btn_lap)        state_nx = ST_RUN;
`else
        state_nx = ST_IDLE;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      overflow <= 1'b0;
    end else begin
      state    <= state_nx;
      overflow <= min_carry;
    end
  end

  mod_counter #(.MAX(SEC_MAX), .W(CNT_W)) u_sec (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .inc       (count_en),
    .count     (sec),
    .carry_out (sec_carry)
  );

  mod_counter #(.MAX(MIN_MAX), .W(CNT_W)) u_min (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .inc       (sec_carry),
    .count     (min),
    .carry_out (min_carry)
  );

  assign start = (state == ST_RUN) || (state == ST_LAP);
  assign pause = (state == ST_PAUSE);

`ifdef LAP_EN
  logic [CNT_W-1:0] lap_sec;
  logic [CNT_W-1:0] lap_min;

  always_ff @(posedge clk) begin
    if (rst) begin
      lap_sec <= '0;
      lap_min <= '0;
    end else if ((state == ST_RUN) && !btn_start_stop && btn_lap) begin
      lap_sec <= sec;
      lap_min <= min;
    end
  end

  assign lap_active = (state == ST_LAP);
  assign sec_out    = lap_active ? lap_sec : sec;
  assign min_out    = lap_active ? lap_min : min;
`else
  logic unused_lap;
  assign unused_lap = btn_lap;
  assign lap_active = 1'b0;
  assign sec_out    = sec;
  assign min_out    = min;
`endif

endmodule

// File: tb/tb_chrono_ctrl.sv
// Directed self-checking bench for chrono_ctrl (covers both LAP_EN builds).
module tb_chrono_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_start_stop = 1'b0;
  logic       btn_lap = 1'b0;
  logic       btn_clear = 1'b0;
  logic       tick = 1'b0;
  logic       start;
  logic       pause;
  logic [5:0] sec_out;
  logic [5:0] min_out;
  logic       lap_active;
  logic       overflow;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  chrono_ctrl #(.SEC_MAX(59), .MIN_MAX(59), .CNT_W(6)) dut (
    .clk            (clk),
    .rst            (rst),
    .btn_start_stop (btn_start_stop),
    .btn_lap        (btn_lap),
    .btn_clear      (btn_clear),
    .tick           (tick),
    .start          (start),
    .pause          (pause),
    .sec_out        (sec_out),
    .min_out        (min_out),
    .lap_active     (lap_active),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Inputs change 1 ns after a rising edge and are sampled at the next one.
  task automatic step(input logic ss, input logic lp, input logic cl, input logic tk);
    btn_start_stop = ss;
    btn_lap        = lp;
    btn_clear      = cl;
    tick           = tk;
    @(posedge clk);
    #1;
    btn_start_stop = 1'b0;
    btn_lap        = 1'b0;
    btn_clear      = 1'b0;
    tick           = 1'b0;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".start"}, 32'(start), 0);
    check({tag, ".pause"}, 32'(pause), 0);
    check({tag, ".sec"}, 32'(sec_out), 0);
    check({tag, ".min"}, 32'(min_out), 0);
    check({tag, ".lap"}, 32'(lap_active), 0);
    check({tag, ".ovf"}, 32'(overflow), 0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();
    check_all_zero("reset");

    // start, three ticks
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("run.start", 32'(start), 1);
    check("run.pause", 32'(pause), 0);
    ticks(3);
    check("run3.sec", 32'(sec_out), 3);
    check("run3.min", 32'(min_out), 0);

    // 0:59 -> 1:00 without overflow
    ticks(56);
    check("s59.sec", 32'(sec_out), 59);
    check("s59.min", 32'(min_out), 0);
    ticks(1);
    check("m1.sec", 32'(sec_out), 0);
    check("m1.min", 32'(min_out), 1);
    check("m1.ovf", 32'(overflow), 0);

    // 59:59 -> 0:00 with one-cycle overflow
    ticks(3539);
    check("full.sec", 32'(sec_out), 59);
    check("full.min", 32'(min_out), 59);
    check("full.ovf", 32'(overflow), 0);
    ticks(1);
    check("wrap.sec", 32'(sec_out), 0);
    check("wrap.min", 32'(min_out), 0);
    check("wrap.ovf", 32'(overflow), 1);
    check("wrap.start", 32'(start), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("wrap.ovf_drop", 32'(overflow), 0);
    ticks(1);
    check("wrap.cont", 32'(sec_out), 1);

    // lap freeze
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(10);
    check("lap0.sec", 32'(sec_out), 10);
    step(1'b0, 1'b1, 1'b0, 1'b0);
`ifdef LAP_EN
    check("lap1.active", 32'(lap_active), 1);
    check("lap1.start", 32'(start), 1);
    ticks(5);
    check("lap5.sec", 32'(sec_out), 10);
    check("lap5.min", 32'(min_out), 0);
    check("lap5.active", 32'(lap_active), 1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("unlap.active", 32'(lap_active), 0);
    check("unlap.sec", 32'(sec_out), 15);
    check("unlap.start", 32'(start), 1);
`else
    check("nolap.active", 32'(lap_active), 0);
    check("nolap.start", 32'(start), 1);
    ticks(5);
    check("nolap5.sec", 32'(sec_out), 15);
    check("nolap5.active", 32'(lap_active), 0);
`endif

    // pause with a same-cycle tick, ignored ticks, clear
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(7);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("pz.sec", 32'(sec_out), 8);
    check("pz.pause", 32'(pause), 1);
    check("pz.start", 32'(start), 0);
    ticks(2);
    check("pz_ign.sec", 32'(sec_out), 8);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check_all_zero("clr");
    ticks(1);
    check("idle_ign.sec", 32'(sec_out), 0);

    // clear beats start_stop and tick in PAUSE
    step(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(4);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("p4.sec", 32'(sec_out), 4);
    check("p4.pause", 32'(pause), 1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    check_all_zero("clrpri");
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("restart.start", 32'(start), 1);

    // reset mid-count (in LAP where built in)
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(150);
    check("t230.min", 32'(min_out), 2);
    check("t230.sec", 32'(sec_out), 30);
`ifdef LAP_EN
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("t230.lap", 32'(lap_active), 1);
`endif
    rst = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    check_all_zero("rst_mid");
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_mid.idle_run", 32'(start), 1);
    check("rst_mid.lapregs", 32'(sec_out), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
